// File: rtl/bitserial_logic_unit_if.sv
// rtl/bitserial_logic_unit_if.sv - start/busy/done operand and result bundle for the bit-serial logic unit
interface bitserial_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;

    modport master (
        output start, op, a, b,
        input  busy, done, y, zero, parity
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, y, zero, parity
    );
endinterface

// File: rtl/bitserial_logic_unit.sv
// rtl/bitserial_logic_unit.sv - multi-cycle bitwise logic unit, LANES bits per clock
module bitserial_logic_unit #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    bitserial_logic_unit_if.slave   bus
);
    localparam int STEPS = (LANES > 0) ? WIDTH / LANES : 1;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_params
        $error("bitserial_logic_unit: WIDTH must be >= 1 and a multiple of LANES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [2:0]       sop_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             parity_q;
    logic [LANES-1:0] r;
    logic             cnt_last;

    function automatic logic [LANES-1:0] lane_fn(input logic [2:0]       fop,
                                                 input logic [LANES-1:0] x,
                                                 input logic [LANES-1:0] z);
        case (fop)
            3'b000:  lane_fn = x & z;
            3'b001:  lane_fn = x | z;
            3'b010:  lane_fn = ~(x & z);
            3'b011:  lane_fn = ~(x | z);
            3'b100:  lane_fn = x ^ z;
            3'b101:  lane_fn = ~(x ^ z);
            3'b110:  lane_fn = ~x;
            default: lane_fn = x;
        endcase
    endfunction

    always_comb begin
        r = lane_fn(sop_q, sa_q[LANES-1:0], sb_q[LANES-1:0]);
    end

    // Lowest lanes are consumed first, so results enter at the MSB and reach bit order of a/b after STEPS shifts.
    if (LANES == WIDTH) begin : g_acc_full
        assign acc_d = r;
    end else begin : g_acc_part
        assign acc_d = {r, acc_q[WIDTH-1:LANES]};
    end

    assign cnt_last = (cnt_q == CNT_W'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sop_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        sop_q   <= bus.op;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> LANES;
                    sb_q  <= sb_q >> LANES;
                    acc_q <= acc_d;
                    if (cnt_last) begin
                        y_q      <= acc_d;
                        zero_q   <= (acc_d == '0);
                        parity_q <= ^acc_d;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.y      = y_q;
    assign bus.zero   = zero_q;
    assign bus.parity = parity_q;
endmodule

// File: tb/tb_bitserial_logic_unit.sv
// tb/tb_bitserial_logic_unit.sv - scoreboard bench: directed scenarios plus random parameter sweep
module tb_bitserial_logic_unit;
    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   sw_finished = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] y;
        logic        zero;
        logic        parity;
        int          accept;
    } exp_t;

    function automatic int cfg_w(input int i);
        case (i)
            0: cfg_w = 1;
            1, 2, 3: cfg_w = 8;
            default: cfg_w = 16;
        endcase
    endfunction

    function automatic int cfg_l(input int i);
        case (i)
            0: cfg_l = 1;
            1: cfg_l = 1;
            2: cfg_l = 2;
            3: cfg_l = 8;
            4: cfg_l = 1;
            5: cfg_l = 2;
            default: cfg_l = 16;
        endcase
    endfunction

    // Whole-word reference: every result bit is f(op, a[i], b[i]).
    function automatic logic [15:0] ref_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input int w);
        logic [31:0] mask;
        logic [15:0] res;
        mask = (32'h1 << w) - 32'h1;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: res = ~(a & b);
            3'd3: res = ~(a | b);
            3'd4: res = a ^ b;
            3'd5: res = ~(a ^ b);
            3'd6: res = ~a;
            default: res = a;
        endcase
        return res & mask[15:0];
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] y, input int accept);
        exp_t e;
        e.y      = y;
        e.zero   = (y == 16'h0);
        e.parity = ^y;
        e.accept = accept;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- directed instances ----------------
    bitserial_logic_unit_if #(.WIDTH(8)) d_bus();
    bitserial_logic_unit_if #(.WIDTH(8)) e_bus();
    bitserial_logic_unit #(.WIDTH(8), .LANES(1)) u_d (.clk(clk), .rst(rst_d), .bus(d_bus.slave));
    bitserial_logic_unit #(.WIDTH(8), .LANES(4)) u_e (.clk(clk), .rst(rst_d), .bus(e_bus.slave));

    exp_t qd[$];
    exp_t qe[$];
    exp_t md;
    exp_t me;

    always @(negedge clk) begin
        if (!rst_d && d_bus.done) begin
            if (qd.size() == 0) begin
                check("d_unexpected_done", 32'd1, 32'd0);
            end else begin
                md = qd.pop_front();
                check("d_y", 32'(d_bus.y), 32'(md.y));
                check("d_zero", 32'(d_bus.zero), 32'(md.zero));
                check("d_parity", 32'(d_bus.parity), 32'(md.parity));
                check("d_latency", 32'(cyc - md.accept), 32'd8);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_d && e_bus.done) begin
            if (qe.size() == 0) begin
                check("e_unexpected_done", 32'd1, 32'd0);
            end else begin
                me = qe.pop_front();
                check("e_y", 32'(e_bus.y), 32'(me.y));
                check("e_zero", 32'(e_bus.zero), 32'(me.zero));
                check("e_parity", 32'(e_bus.parity), 32'(me.parity));
                check("e_latency", 32'(cyc - me.accept), 32'd2);
            end
        end
    end

    task automatic d_wait_idle();
        int n = 0;
        while (d_bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("d_idle_reached", 32'(d_bus.busy), 32'd0);
    endtask

    task automatic e_wait_idle();
        int n = 0;
        while (e_bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("e_idle_reached", 32'(e_bus.busy), 32'd0);
    endtask

    task automatic d_issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ey);
        d_wait_idle();
        d_bus.start = 1'b1;
        d_bus.op    = op;
        d_bus.a     = a;
        d_bus.b     = b;
        qd.push_back(mk_exp(16'(ey), cyc + 1));
        @(negedge clk);
        d_bus.start = 1'b0;
    endtask

    task automatic e_issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ey);
        e_wait_idle();
        e_bus.start = 1'b1;
        e_bus.op    = op;
        e_bus.a     = a;
        e_bus.b     = b;
        qe.push_back(mk_exp(16'(ey), cyc + 1));
        @(negedge clk);
        e_bus.start = 1'b0;
    endtask

    // ---------------- random parameter sweep ----------------
    for (genvar g = 0; g < 7; g++) begin : sw
        localparam int W = cfg_w(g);
        localparam int L = cfg_l(g);
        localparam int S = W / L;

        bitserial_logic_unit_if #(.WIDTH(W)) bus();
        bitserial_logic_unit #(.WIDTH(W), .LANES(L)) dut (.clk(clk), .rst(rst_s), .bus(bus.slave));

        exp_t q[$];
        exp_t mon_e;

        always @(negedge clk) begin
            if (!rst_s && bus.done) begin
                if (q.size() == 0) begin
                    check($sformatf("sw%0d_unexpected_done", g), 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check($sformatf("sw%0d_y", g), 32'(bus.y), 32'(mon_e.y));
                    check($sformatf("sw%0d_zero", g), 32'(bus.zero), 32'(mon_e.zero));
                    check($sformatf("sw%0d_parity", g), 32'(bus.parity), 32'(mon_e.parity));
                    check($sformatf("sw%0d_latency", g), 32'(cyc - mon_e.accept), 32'(S));
                end
            end
        end

        initial begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [2:0]   rop;
            int           n;
            bus.start = 1'b0;
            bus.op    = 3'd0;
            bus.a     = '0;
            bus.b     = '0;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 200; i++) begin
                n = 0;
                while (bus.busy && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (bus.busy) check($sformatf("sw%0d_idle_timeout", g), 32'd1, 32'd0);
                ra  = W'($urandom);
                rb  = W'($urandom);
                rop = 3'($urandom_range(0, 7));
                bus.start = 1'b1;
                bus.op    = rop;
                bus.a     = ra;
                bus.b     = rb;
                q.push_back(mk_exp(ref_fn(rop, 16'(ra), 16'(rb), W), cyc + 1));
                @(negedge clk);
                bus.start = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    bus.start = 1'b1;
                    bus.op    = 3'($urandom_range(0, 7));
                    bus.a     = W'($urandom);
                    bus.b     = W'($urandom);
                    @(negedge clk);
                    bus.start = 1'b0;
                end
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            n = 0;
            while (bus.busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            check($sformatf("sw%0d_queue_drained", g), 32'(q.size()), 32'd0);
            sw_finished++;
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int          busy_cnt;
        int          prev_acc;
        int          n;
        int          seen_busy;
        logic [7:0]  b2b_y [8];
        b2b_y = '{8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h5A, 8'hA5};

        d_bus.start = 1'b0; d_bus.op = 3'd0; d_bus.a = 8'h0; d_bus.b = 8'h0;
        e_bus.start = 1'b0; e_bus.op = 3'd0; e_bus.a = 8'h0; e_bus.b = 8'h0;

        @(negedge clk);
        check("rst_busy", 32'(d_bus.busy), 32'd0);
        check("rst_done", 32'(d_bus.done), 32'd0);
        check("rst_y", 32'(d_bus.y), 32'h0);
        check("rst_zero", 32'(d_bus.zero), 32'd1);
        check("rst_parity", 32'(d_bus.parity), 32'd0);
        rst_d = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);

        // single AND, busy duration
        d_issue(3'b000, 8'hA5, 8'h3C, 8'h24);
        busy_cnt = 0;
        while (d_bus.busy && busy_cnt < 50) begin
            busy_cnt++;
            @(negedge clk);
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd9);
        check("t1_y_held", 32'(d_bus.y), 32'h24);
        check("t1_zero", 32'(d_bus.zero), 32'd0);
        check("t1_parity", 32'(d_bus.parity), 32'd0);

        // all eight ops back to back, start held high
        prev_acc = 0;
        for (int k = 0; k < 8; k++) begin
            d_wait_idle();
            d_bus.start = 1'b1;
            d_bus.op    = 3'(k);
            d_bus.a     = 8'hA5;
            d_bus.b     = 8'h3C;
            qd.push_back(mk_exp(16'(b2b_y[k]), cyc + 1));
            if (k > 0) check("b2b_spacing", 32'(cyc + 1 - prev_acc), 32'd10);
            prev_acc = cyc + 1;
            @(negedge clk);
        end
        d_bus.start = 1'b0;
        d_wait_idle();
        check("b2b_last_y", 32'(d_bus.y), 32'hA5);

        // LANES=4 unit
        e_issue(3'b101, 8'hF0, 8'h0F, 8'h00);
        e_wait_idle();
        check("e_xnor_zero", 32'(e_bus.zero), 32'd1);
        e_issue(3'b111, 8'h07, 8'($urandom), 8'h07);
        e_wait_idle();
        check("e_pass_parity", 32'(e_bus.parity), 32'd1);

        // start and input changes while busy are ignored
        d_issue(3'b100, 8'h5C, 8'h33, 8'h6F);
        @(negedge clk);
        d_bus.start = 1'b1;
        d_bus.op    = 3'b000;
        d_bus.a     = 8'hFF;
        d_bus.b     = 8'hFF;
        @(negedge clk);
        d_bus.start = 1'b0;
        d_bus.a     = 8'($urandom);
        d_bus.b     = 8'($urandom);
        d_bus.op    = 3'($urandom_range(0, 7));
        d_wait_idle();
        seen_busy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (d_bus.busy) seen_busy = 1;
        end
        check("busy_no_second_op", 32'(seen_busy), 32'd0);
        check("busy_y_kept", 32'(d_bus.y), 32'h6F);

        // asynchronous reset mid-RUN
        d_issue(3'b000, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        #2;
        rst_d = 1'b1;
        #1;
        check("arst_busy", 32'(d_bus.busy), 32'd0);
        check("arst_done", 32'(d_bus.done), 32'd0);
        check("arst_y", 32'(d_bus.y), 32'h0);
        check("arst_zero", 32'(d_bus.zero), 32'd1);
        check("arst_parity", 32'(d_bus.parity), 32'd0);
        void'(qd.pop_back());
        @(negedge clk);
        rst_d = 1'b0;
        d_issue(3'b001, 8'h0F, 8'hF0, 8'hFF);
        d_wait_idle();
        check("arst_after_y", 32'(d_bus.y), 32'hFF);
        @(negedge clk);
        check("d_queue_drained", 32'(qd.size()), 32'd0);
        check("e_queue_drained", 32'(qe.size()), 32'd0);

        n = 0;
        while (sw_finished < 7 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_finished", 32'(sw_finished), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
